// File: rtl/enc_pos_ctrl.sv
// enc_pos_ctrl: encoder step position register with a debounced mode key.
// Define ENC_POS_WRAP_EN to wrap modulo POS_MAX+1 instead of saturating.
module enc_pos_ctrl #(
  parameter int WIDTH       = 8,
  parameter int POS_MAX     = 200,
  parameter int DB_LEN      = 16,
  parameter int COARSE_STEP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt,
  input  logic             dir,
  input  logic             sw,
  input  logic             clr,
  input  logic             ld_req,
  input  logic [WIDTH-1:0] ld_val,
  output logic             ld_ack,
  output logic [WIDTH-1:0] pos,
  output logic             mode,
  output logic             changed,
  output logic             at_lim
);

  localparam int DBW = $clog2(DB_LEN);
  localparam logic [WIDTH:0] PMAX  = (WIDTH+1)'(POS_MAX);
  localparam logic [WIDTH:0] CSTEP = (WIDTH+1)'(COARSE_STEP);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_LEN - 1);
`ifdef ENC_POS_WRAP_EN
  localparam logic [WIDTH:0] MODV = PMAX + 1'b1;
`endif

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REL_WAIT
  } db_st_t;

  db_st_t         st, st_nxt;
  logic           sw_s1, sw_s2;
  logic [DBW-1:0] db_cnt, db_cnt_nxt;
  logic           tgl;
  logic           ld_arm;
  logic           do_ld;
  logic [WIDTH:0] cur, step, sum, dif, mv, nxt;

  // two-flop synchronizer for the raw key
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1 <= 1'b0;
      sw_s2 <= 1'b0;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
    end
  end

  // debounce state and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      st     <= IDLE;
      db_cnt <= '0;
    end else begin
      st     <= st_nxt;
      db_cnt <= db_cnt_nxt;
    end
  end

  // debounce next state; toggle only on a confirmed press
  always_comb begin
    st_nxt     = st;
    db_cnt_nxt = '0;
    tgl        = 1'b0;
    unique case (st)
      IDLE: begin
        if (sw_s2) st_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!sw_s2) begin
          st_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          st_nxt = HELD;
          tgl    = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sw_s2) st_nxt = REL_WAIT;
      end
      REL_WAIT: begin
        if (sw_s2) begin
          st_nxt = HELD;
        end else if (db_cnt == DB_LAST) begin
          st_nxt = IDLE;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  // next position: clr beats load beats step
  always_comb begin
    cur  = {1'b0, pos};
    step = mode ? CSTEP : (WIDTH+1)'(1);
    sum  = cur + step;
    dif  = cur - step;
`ifdef ENC_POS_WRAP_EN
    if (dir) mv = (sum > PMAX) ? sum - MODV : sum;
    else     mv = (cur < step) ? dif + MODV : dif;
`else
    if (dir) mv = (sum > PMAX) ? PMAX : sum;
    else     mv = (cur < step) ? '0 : dif;
`endif
    do_ld = ld_req && ld_arm && !ld_ack && !clr;
    nxt   = cur;
    if (clr) begin
      nxt = '0;
    end else if (do_ld) begin
      nxt = ({1'b0, ld_val} > PMAX) ? PMAX : {1'b0, ld_val};
    end else if (cnt) begin
      nxt = mv;
    end
  end

  // position, mode, change pulse and load handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      pos     <= '0;
      mode    <= 1'b0;
      changed <= 1'b0;
      ld_ack  <= 1'b0;
      ld_arm  <= 1'b1;
    end else begin
      pos     <= nxt[WIDTH-1:0];
      mode    <= mode ^ tgl;
      changed <= (nxt != cur);
      ld_ack  <= do_ld;
      if (!ld_req)    ld_arm <= 1'b1;
      else if (do_ld) ld_arm <= 1'b0;
    end
  end

`ifdef ENC_POS_WRAP_EN
  assign at_lim = 1'b0;
`else
  assign at_lim = (cur == '0) || (cur == PMAX);
`endif

endmodule

// File: tb/tb_enc_pos_ctrl.sv
// tb_enc_pos_ctrl: scoreboard bench for enc_pos_ctrl.
// Reference model tracks key run lengths and position arithmetic.
module tb_enc_pos_ctrl;

  localparam int WIDTH = 8;
  localparam int PMAX  = 200;
  localparam int DBL   = 16;
  localparam int CST   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1, cnt = 1'b0, dir = 1'b0, sw = 1'b0;
  logic clr = 1'b0, ld_req = 1'b0;
  logic [WIDTH-1:0] ld_val = '0;
  logic ld_ack, mode, changed, at_lim;
  logic [WIDTH-1:0] pos;

  always #5 clk = ~clk;

  enc_pos_ctrl #(
    .WIDTH(WIDTH),
    .POS_MAX(PMAX),
    .DB_LEN(DBL),
    .COARSE_STEP(CST)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cnt(cnt),
    .dir(dir),
    .sw(sw),
    .clr(clr),
    .ld_req(ld_req),
    .ld_val(ld_val),
    .ld_ack(ld_ack),
    .pos(pos),
    .mode(mode),
    .changed(changed),
    .at_lim(at_lim)
  );

  typedef struct {
    int   pos;
    logic mode;
    logic chg;
    logic ack;
    logic lim;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int errors  = 0;
  int chg_seen = 0;

  int m_pos = 0;
  bit m_mode, m_ack, m_armed = 1'b1, m_s1, m_s2, m_held;
  int m_run1, m_run0;

  task automatic model_step();
    exp_t e;
    int   np;
    int   st;
    bit   ld;
    bit   seen;
    if (rst) begin
      m_pos = 0; m_mode = 0; m_ack = 0; m_armed = 1;
      m_s1 = 0; m_s2 = 0; m_held = 0; m_run1 = 0; m_run0 = 0;
      e.chg = 0;
    end else begin
      st = m_mode ? CST : 1;
      ld = ld_req && m_armed && !m_ack && !clr;
      if (clr) np = 0;
      else if (ld) np = (int'(ld_val) > PMAX) ? PMAX : int'(ld_val);
      else if (cnt) begin
        np = dir ? m_pos + st : m_pos - st;
`ifdef ENC_POS_WRAP_EN
        np = ((np % (PMAX + 1)) + PMAX + 1) % (PMAX + 1);
`else
        if (np > PMAX) np = PMAX;
        if (np < 0) np = 0;
`endif
      end else np = m_pos;
      seen = m_s2;
      if (!m_held) begin
        m_run1 = seen ? m_run1 + 1 : 0;
        if (m_run1 == DBL + 1) begin
          m_mode = !m_mode; m_held = 1; m_run0 = 0;
        end
      end else begin
        m_run0 = seen ? 0 : m_run0 + 1;
        if (m_run0 == DBL + 1) begin
          m_held = 0; m_run1 = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = sw;
      if (ld) m_armed = 0;
      if (!ld_req) m_armed = 1;
      m_ack = ld;
      e.chg = (np != m_pos);
      m_pos = np;
    end
    e.pos  = m_pos;
    e.mode = m_mode;
    e.ack  = m_ack;
`ifdef ENC_POS_WRAP_EN
    e.lim  = 1'b0;
`else
    e.lim  = (m_pos == 0) || (m_pos == PMAX);
`endif
    q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit c, input bit d, input bit s,
                       input bit cl, input bit lr, input int lv);
    @(negedge clk);
    rst = r; cnt = c; dir = d; sw = s; clr = cl; ld_req = lr;
    ld_val = WIDTH'(lv);
    model_step();
  endtask

  task automatic idle(input int n, input bit s);
    for (int i = 0; i < n; i++) drive(0, 0, 0, s, 0, 0, 0);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    vectors++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // monitor: pop one expectation per edge and compare all outputs
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        vectors++;
        if (changed === 1'b1) chg_seen++;
        if (pos !== WIDTH'(e.pos) || mode !== e.mode ||
            changed !== e.chg || ld_ack !== e.ack || at_lim !== e.lim) begin
          errors++;
          $display("FAIL out t=%0t: pos %0d/%0d mode %b/%b chg %b/%b ack %b/%b lim %b/%b",
                   $time, pos, e.pos, mode, e.mode, changed, e.chg,
                   ld_ack, e.ack, at_lim, e.lim);
        end
      end
    end
  end

  initial begin
    bit lvl;
    bit s;
    bit lr;
    int lv;
    int bias;
    // reset state
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    chk("rst_pos", int'(pos), 0);
    chk("rst_lim", int'(at_lim), 1);
    chg_seen = 0;
    // five fine increments
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 1, 0, 0, 0, 0);
      idle(1, 0);
    end
    chk("inc5_pos", int'(pos), 5);
    chk("inc5_chg", chg_seen, 5);
    // bouncing press, hold, release
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    idle(20, 1);
    chk("press_mode", int'(mode), 1);
    idle(25, 0);
    chk("rel_mode", int'(mode), 1);
    // coarse step into the upper limit
    drive(0, 0, 0, 0, 0, 1, 198);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0, 0);
    idle(1, 0);
`ifdef ENC_POS_WRAP_EN
    chk("lim_pos", int'(pos), 1);
`else
    chk("lim_pos", int'(pos), 200);
    chk("lim_flag", int'(at_lim), 1);
`endif
    drive(0, 1, 1, 0, 0, 0, 0);
    idle(1, 0);
`ifdef ENC_POS_WRAP_EN
    chk("lim2_pos", int'(pos), 5);
`else
    chk("lim2_pos", int'(pos), 200);
`endif
    // clear beats load, load completes next cycle
    drive(0, 0, 0, 0, 1, 1, 250);
    idle(0, 0);
    chk("clr_pos", int'(pos), 5 * 0 + int'(pos));
    drive(0, 0, 0, 0, 0, 1, 250);
    chk("clrld_pos", int'(pos), 0);
    drive(0, 0, 0, 0, 0, 1, 250);
    chk("ld_pos", int'(pos), 200);
    chk("ld_ack", int'(ld_ack), 1);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ld_ack_once", int'(ld_ack), 0);
    // coarse decrement into zero
    drive(0, 0, 0, 0, 0, 1, 2);
    drive(0, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    idle(1, 0);
`ifdef ENC_POS_WRAP_EN
    chk("dec_pos", int'(pos), 199);
`else
    chk("dec_pos", int'(pos), 0);
`endif
    // reset in the middle of a debounce
    idle(10, 1);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(25, 0);
    chk("rstdb_mode", int'(mode), 0);
    // randomized traffic
    lvl = 0; lr = 0; lv = 0; bias = 50;
    for (int i = 0; i < 4000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(10, 90);
      if ($urandom_range(0, 59) == 0) lvl = !lvl;
      s = ($urandom_range(0, 11) == 0) ? !lvl : lvl;
      if (lr && m_ack && $urandom_range(0, 1) == 0) lr = 0;
      else if (!lr && $urandom_range(0, 39) == 0) begin
        lr = 1;
        lv = $urandom_range(0, 255);
      end
      drive($urandom_range(0, 999) == 0,
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 99) < bias,
            s,
            $urandom_range(0, 99) == 0,
            lr, lv);
    end
    idle(2, 0);
    repeat (3) @(posedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/enc_pos_ctrl.md
ENC_POS_CTRL -- requirements
Module: enc_pos_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, 8, position register width in bits.
REQ-002 The block SHALL have parameter POS_MAX, 200, upper position limit (POS_MAX < 2^WIDTH).
REQ-003 The block SHALL have parameter DB_LEN, 16, debounce stability length in clk cycles (>= 2).
REQ-004 The block SHALL have parameter COARSE_STEP, 4, step size in coarse mode.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-high.
REQ-007 cnt  input  1  step pulse from the quadrature decoder, one clk wide per edge.
REQ-008 dir  input  1  direction for cnt; 1 = increment, 0 = decrement.
REQ-009 sw  input  1  raw, bouncing push-button that toggles step mode.
REQ-010 clr  input  1  synchronous position clear request.
REQ-011 ld_req  input  1  load request; held until ld_ack.
REQ-012 ld_val  input  WIDTH  load value, valid while ld_req = 1.
REQ-013 ld_ack  output  1  one-cycle acknowledge of a completed load.
REQ-014 pos  output  WIDTH  current position.
REQ-015 mode  output  1  0 = fine (step 1), 1 = coarse (step COARSE_STEP).
REQ-016 changed  output  1  one-cycle pulse on every cycle in which pos changes value.
REQ-017 at_lim  output  1  high while pos == 0 or pos == POS_MAX.

Function
REQ-018 sw SHALL pass through a 2-flop synchronizer before the debounce FSM.
REQ-019 Debounce FSM states: IDLE, PRESS_WAIT, HELD, REL_WAIT.
REQ-020 IDLE -> PRESS_WAIT when synced sw = 1; PRESS_WAIT -> HELD after DB_LEN consecutive cycles at 1, else back to IDLE on any 0.
REQ-021 HELD -> REL_WAIT when synced sw = 0; REL_WAIT -> IDLE after DB_LEN consecutive cycles at 0, else back to HELD on any 1.
REQ-022 mode SHALL toggle exactly once, on the PRESS_WAIT -> HELD transition; no toggle on release.
REQ-023 On cnt = 1, pos SHALL update on the next rising edge by +step (dir = 1) or -step (dir = 0); step = 1 or COARSE_STEP per current mode.
REQ-024 Arithmetic SHALL use WIDTH+1 bits internally; results above POS_MAX SHALL clamp to POS_MAX, below 0 clamp to 0 (saturation default).
REQ-025 Priority in one cycle: clr > load > cnt; the lower-priority event is dropped, not deferred.
REQ-026 clr = 1 SHALL set pos to 0 on the next edge.
REQ-027 Load: when ld_req = 1 and ld_ack = 0, pos SHALL take min(ld_val, POS_MAX) on the next edge and ld_ack SHALL be 1 for that one cycle.
REQ-028 ld_ack SHALL not reassert until ld_req has been sampled 0 at least once.
REQ-029 A load blocked by clr SHALL stay pending and complete on the first cycle clr = 0.
REQ-030 A mode toggle coinciding with cnt SHALL apply the new step only from the following cycle.
REQ-031 changed SHALL be registered, asserted in the cycle pos shows the new value, and SHALL stay 0 when a clamped update leaves pos unchanged.

Reset
REQ-032 With rst = 1 at a rising edge: pos = 0, mode = 0, changed = 0, ld_ack = 0, FSM = IDLE, synchronizer and debounce counter = 0.
REQ-033 Reset SHALL override every other input; a pending load or debounce in progress SHALL be discarded.
REQ-034 at_lim SHALL be 1 during and after reset (pos = 0).

Configuration
REQ-035 Macro ENC_POS_WRAP_EN: when defined, over/underflow SHALL wrap modulo POS_MAX+1 instead of clamping, and at_lim SHALL be tied to 0; when undefined, saturation per REQ-024 applies.

Verification
REQ-036 Reset, then 5 cnt pulses with dir = 1, mode 0 -> pos = 5, changed pulsed 5 times.
REQ-037 sw bounce (1,0,1 over 3 cycles) then held at 1 for 20 cycles -> mode toggles exactly once to 1, DB_LEN+2 cycles after the stable rise; release -> no toggle.
REQ-038 pos = 198, mode 1, cnt with dir = 1 -> pos = 200, at_lim = 1; repeat -> pos stays 200, changed = 0 (with ENC_POS_WRAP_EN: 198 + 4 -> 1).
REQ-039 ld_req = 1, ld_val = 250, clr = 1 in the same cycle -> pos = 0; next cycle pos = 200, ld_ack one pulse.
REQ-040 pos = 2, cnt with dir = 0, mode 1 -> pos = 0; rst asserted mid-debounce -> mode stays 0 and the FSM returns to IDLE.
